// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl
//   Guess-checking combination lock. A guess word is accepted only while the
//   lock is LOCKED, compared against the stored key one cycle later (CHECK),
//   and the outcome is reported on a one-cycle result pulse. A correct guess
//   opens the lock; in OPEN the key may be replaced and the lock re-armed.
//   NTRIES consecutive wrong guesses force a LOCKOUT lasting LOCKOUT_CYCLES
//   cycles, during which all guesses are ignored.
//
// Ports
//   clk          : single clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   guess_valid  : a guess word is offered this cycle
//   guess        : guess word (NBITS)
//   guess_ready  : lock accepts a guess this cycle (LOCKED only)
//   key_load     : load key_in into the key register (OPEN only)
//   key_in       : new key value (NBITS)
//   relock       : leave OPEN and return to LOCKED
//   unlocked     : high while OPEN
//   alarm        : high while in LOCKOUT
//   result_valid : one-cycle pulse after a guess has been evaluated
//   result_match : outcome of the evaluated guess, qualified by result_valid
//   fail_cnt     : consecutive wrong-guess count
module code_lock_ctrl #(
  parameter int               NBITS          = 16,
  parameter int               NTRIES         = 3,
  parameter int               LOCKOUT_CYCLES = 8,
  parameter logic [NBITS-1:0] RESET_KEY      = 16'hBEEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             guess_valid,
  input  logic [NBITS-1:0] guess,
  output logic             guess_ready,
  input  logic             key_load,
  input  logic [NBITS-1:0] key_in,
  input  logic             relock,
  output logic             unlocked,
  output logic             alarm,
  output logic             result_valid,
  output logic             result_match,
  output logic [3:0]       fail_cnt
);

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [3:0]  NTRIES_C  = 4'(NTRIES);
  localparam logic [15:0] LOCKOUT_C = 16'(LOCKOUT_CYCLES);

  // Full-width equality: every XOR bit must be zero.
  function automatic logic words_match(input logic [NBITS-1:0] a,
                                       input logic [NBITS-1:0] b);
    return ~|(a ^ b);
  endfunction

  state_t           state_r;
  logic [NBITS-1:0] key_r;
  logic [NBITS-1:0] guess_r;
  logic [3:0]       fail_cnt_r;
  logic [15:0]      timer_r;
  logic             guess_ready_r;
  logic             unlocked_r;
  logic             alarm_r;
  logic             result_valid_r;
  logic             result_match_r;

  logic             match_s;
  logic [3:0]       fail_next_s;

  assign match_s     = words_match(guess_r, key_r);
  assign fail_next_s = fail_cnt_r + 4'd1;

  // Lock FSM: state, key, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_LOCKED;
      key_r          <= RESET_KEY;
      guess_r        <= '0;
      fail_cnt_r     <= 4'd0;
      timer_r        <= 16'd0;
      guess_ready_r  <= 1'b1;
      unlocked_r     <= 1'b0;
      alarm_r        <= 1'b0;
      result_valid_r <= 1'b0;
      result_match_r <= 1'b0;
    end else begin
      // The result flags are a pulse; only the CHECK state raises them.
      result_valid_r <= 1'b0;
      result_match_r <= 1'b0;
      case (state_r)
        ST_LOCKED: begin
          if (guess_valid && guess_ready_r) begin
            guess_r       <= guess;
            state_r       <= ST_CHECK;
            guess_ready_r <= 1'b0;
          end else begin
            guess_ready_r <= 1'b1;
          end
        end
        ST_CHECK: begin
          result_valid_r <= 1'b1;
          result_match_r <= match_s;
          if (match_s) begin
            state_r    <= ST_OPEN;
            fail_cnt_r <= 4'd0;
            unlocked_r <= 1'b1;
          end else if (fail_next_s >= NTRIES_C) begin
            // Last permitted miss: hold the count at NTRIES for the lockout.
            state_r    <= ST_LOCKOUT;
            fail_cnt_r <= NTRIES_C;
            timer_r    <= LOCKOUT_C;
            alarm_r    <= 1'b1;
          end else begin
            state_r       <= ST_LOCKED;
            fail_cnt_r    <= fail_next_s;
            guess_ready_r <= 1'b1;
          end
        end
        ST_OPEN: begin
          // Key write and relock are independent and may share an edge.
          if (key_load) begin
            key_r <= key_in;
          end
          if (relock) begin
            state_r       <= ST_LOCKED;
            unlocked_r    <= 1'b0;
            guess_ready_r <= 1'b1;
          end
        end
        ST_LOCKOUT: begin
          // Leaving on timer==1 gives exactly LOCKOUT_CYCLES alarm cycles.
          if (timer_r <= 16'd1) begin
            state_r       <= ST_LOCKED;
            timer_r       <= 16'd0;
            fail_cnt_r    <= 4'd0;
            alarm_r       <= 1'b0;
            guess_ready_r <= 1'b1;
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        default: begin
          state_r       <= ST_LOCKED;
          timer_r       <= 16'd0;
          fail_cnt_r    <= 4'd0;
          unlocked_r    <= 1'b0;
          alarm_r       <= 1'b0;
          guess_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign guess_ready  = guess_ready_r;
  assign unlocked     = unlocked_r;
  assign alarm        = alarm_r;
  assign result_valid = result_valid_r;
  assign result_match = result_match_r;
  assign fail_cnt     = fail_cnt_r;

endmodule
